// File: rtl/score_material_seq_if.sv
// Handshake, board-read and value-table bus of the sequential material evaluator.
// The slave modport is the evaluator; the master side is the controller plus board store.
interface score_material_seq_if #(
  parameter int SQUARES = 64,
  parameter int LANES   = 1,
  parameter int VAL_W   = 4,
  parameter int SCORE_W = 16
);
  localparam int ADDR_W = ((SQUARES / LANES) > 1) ? $clog2(SQUARES / LANES) : 1;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [4*LANES-1:0]   rd_data;
  logic                 val_we;
  logic [2:0]           val_idx;
  logic [VAL_W-1:0]     val_data;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   white_mat;
  logic [SCORE_W-1:0]   black_mat;

  modport slave (
    input  start, rd_data, val_we, val_idx, val_data,
    output busy, done, rd_en, rd_addr, score, white_mat, black_mat
  );

  modport master (
    output start, rd_data, val_we, val_idx, val_data,
    input  busy, done, rd_en, rd_addr, score, white_mat, black_mat
  );
endinterface

// File: rtl/score_material_seq.sv
// Sequential material evaluator: streams the board LANES squares per cycle from the
// board RAM and accumulates white/black material using a programmable piece-value table.
module score_material_seq #(
  parameter int SQUARES = 64,
  parameter int LANES   = 1,
  parameter int VAL_W   = 4,
  parameter int SCORE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  score_material_seq_if.slave        bus
);
  localparam int N      = SQUARES / LANES;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [SCORE_W-1:0]  r_acc_white;
  logic [SCORE_W-1:0]  r_acc_black;
  logic [SCORE_W-1:0]  r_white;
  logic [SCORE_W-1:0]  r_black;
  logic [SCORE_W-1:0]  r_score;
  logic [VAL_W-1:0]    r_val [1:6];

  logic                w_busy;
  logic                w_done;
  logic                w_rd_en;
  logic                w_accum;
  logic [3:0]          w_sq;
  logic [VAL_W-1:0]    w_piece_val;
  logic [SCORE_W-1:0]  w_lane_white;
  logic [SCORE_W-1:0]  w_lane_black;
  logic [SCORE_W-1:0]  w_white_total;
  logic [SCORE_W-1:0]  w_black_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Read data lags the address by one cycle, so the first SCAN cycle has nothing to add.
  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_rd_en = 1'b0;
    w_accum = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_SCAN;
      end
      S_SCAN: begin
        w_rd_en = 1'b1;
        w_accum = (r_addr != '0);
        if (r_addr == LAST_ADDR) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_accum = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_lane_white = '0;
    w_lane_black = '0;
    w_sq         = '0;
    w_piece_val  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sq = bus.rd_data[4*l +: 4];
      case (w_sq[2:0])
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: w_piece_val = r_val[w_sq[2:0]];
        default:                            w_piece_val = '0;
      endcase
      if (w_sq[3]) w_lane_black = w_lane_black + SCORE_W'(w_piece_val);
      else         w_lane_white = w_lane_white + SCORE_W'(w_piece_val);
    end
  end

  assign w_white_total = r_acc_white + w_lane_white;
  assign w_black_total = r_acc_black + w_lane_black;

  // Results are registered on the DRAIN->DONE edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_acc_white <= '0;
      r_acc_black <= '0;
      r_white     <= '0;
      r_black     <= '0;
      r_score     <= '0;
      r_val[1]    <= VAL_W'(1);
      r_val[2]    <= VAL_W'(3);
      r_val[3]    <= VAL_W'(3);
      r_val[4]    <= VAL_W'(5);
      r_val[5]    <= VAL_W'(10);
      r_val[6]    <= VAL_W'(0);
    end else begin
      if (w_accum) begin
        r_acc_white <= w_white_total;
        r_acc_black <= w_black_total;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_addr      <= '0;
            r_acc_white <= '0;
            r_acc_black <= '0;
          end
          if (bus.val_we && bus.val_idx != 3'd0 && bus.val_idx != 3'd7)
            r_val[bus.val_idx] <= bus.val_data;
        end
        S_SCAN: begin
          r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        end
        S_DRAIN: begin
          r_white <= w_white_total;
          r_black <= w_black_total;
          r_score <= w_white_total - w_black_total;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = r_addr;
  assign bus.score     = r_score;
  assign bus.white_mat = r_white;
  assign bus.black_mat = r_black;
endmodule

// File: tb/tb_score_material_seq.sv
// Directed bench: runs a LANES=1 and a LANES=8 evaluator in lockstep over the same
// board image and compares results, latencies and control behaviour to hand-computed values.
module tb_score_material_seq;
  logic clk;
  logic rst_n;
  logic [3:0] board [0:63];
  int nChecks;
  int nFails;

  score_material_seq_if #(.SQUARES(64), .LANES(1), .VAL_W(4), .SCORE_W(16)) bus1 ();
  score_material_seq_if #(.SQUARES(64), .LANES(8), .VAL_W(4), .SCORE_W(16)) bus8 ();

  score_material_seq #(.SQUARES(64), .LANES(1), .VAL_W(4), .SCORE_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  score_material_seq #(.SQUARES(64), .LANES(8), .VAL_W(4), .SCORE_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM models: one-cycle read latency, one square resp. eight squares per word.
  always @(posedge clk) begin
    if (bus1.rd_en) bus1.rd_data <= board[bus1.rd_addr];
    if (bus8.rd_en)
      for (int l = 0; l < 8; l++) bus8.rd_data[4*l +: 4] <= board[{bus8.rd_addr, 3'(l)}];
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic driveCtl(input logic s, input logic we, input logic [2:0] idx, input logic [3:0] data);
    bus1.start = s;  bus1.val_we = we;  bus1.val_idx = idx;  bus1.val_data = data;
    bus8.start = s;  bus8.val_we = we;  bus8.val_idx = idx;  bus8.val_data = data;
  endtask

  task automatic loadStart();
    logic [3:0] backRank [0:7];
    backRank = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    for (int f = 0; f < 8; f++) begin
      board[f]      = backRank[f];
      board[8 + f]  = 4'd1;
      board[48 + f] = 4'd9;
      board[56 + f] = backRank[f] | 4'd8;
    end
  endtask

  task automatic writeTable(input logic [2:0] idx, input logic [3:0] data);
    @(negedge clk); driveCtl(1'b0, 1'b1, idx, data);
    @(negedge clk); driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  // One evaluation on both instances; optional stray start and table write while busy.
  task automatic applyStimulus(input string tag, input int expW, input int expB, input int expS,
                               input bit midStart, input bit midWrite);
    int d1Cyc, d8Cyc, d1Cnt, d8Cnt, addrExp, addrErr;
    d1Cyc = 0; d8Cyc = 0; d1Cnt = 0; d8Cnt = 0; addrExp = 0; addrErr = 0;
    @(negedge clk); driveCtl(1'b1, 1'b0, 3'd0, 4'd0);
    @(negedge clk); driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
    for (int cyc = 1; cyc <= 75; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (midWrite && cyc == 3) driveCtl(1'b0, 1'b1, 3'd1, 4'd7);
      if (midWrite && cyc == 4) driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
      if (midStart && cyc == 5) driveCtl(1'b1, 1'b0, 3'd0, 4'd0);
      if (midStart && cyc == 6) driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
      if (bus1.done) begin d1Cnt++; d1Cyc = cyc; end
      if (bus8.done) begin d8Cnt++; d8Cyc = cyc; end
      if (bus1.rd_en) begin
        if (int'(bus1.rd_addr) != addrExp) addrErr++;
        addrExp++;
      end
    end
    checkOutput({tag, " done cycle L1"}, d1Cyc, 66);
    checkOutput({tag, " done cycle L8"}, d8Cyc, 10);
    checkOutput({tag, " done count L1"}, d1Cnt, 1);
    checkOutput({tag, " done count L8"}, d8Cnt, 1);
    checkOutput({tag, " addr reads L1"}, addrExp, 64);
    checkOutput({tag, " addr order L1"}, addrErr, 0);
    checkOutput({tag, " white L1"}, int'(bus1.white_mat), expW);
    checkOutput({tag, " black L1"}, int'(bus1.black_mat), expB);
    checkOutput({tag, " score L1"}, int'($signed(bus1.score)), expS);
    checkOutput({tag, " white L8"}, int'(bus8.white_mat), expW);
    checkOutput({tag, " black L8"}, int'(bus8.black_mat), expB);
    checkOutput({tag, " score L8"}, int'($signed(bus8.score)), expS);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    bus1.rd_data = '0;
    bus8.rd_data = '0;
    driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
    loadStart();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset busy",    int'(bus1.busy),      0);
    checkOutput("reset done",    int'(bus1.done),      0);
    checkOutput("reset rd_en",   int'(bus1.rd_en),     0);
    checkOutput("reset rd_addr", int'(bus1.rd_addr),   0);
    checkOutput("reset score",   int'(bus1.score),     0);
    checkOutput("reset white",   int'(bus1.white_mat), 0);
    checkOutput("reset black",   int'(bus1.black_mat), 0);
    checkOutput("reset busy L8", int'(bus8.busy),      0);

    // Start position with default values: 8*1 + 2*3 + 2*3 + 2*5 + 10 + 0 = 40 per side.
    applyStimulus("startpos", 40, 40, 0, 1'b0, 1'b0);
    board[59] = 4'd0;
    applyStimulus("no black queen", 40, 30, 10, 1'b0, 1'b0);
    board[0] = 4'd0;
    board[8] = 4'd0;
    applyStimulus("minus rook pawn", 34, 30, 4, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    applyStimulus("empty", 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) board[i] = i[0] ? 4'hF : 4'h7;
    writeTable(3'd0, 4'd15);
    writeTable(3'd7, 4'd15);
    applyStimulus("type7", 0, 0, 0, 1'b0, 1'b0);

    loadStart();
    writeTable(3'd2, 4'd4);
    writeTable(3'd6, 4'd2);
    applyStimulus("reprog startpos", 44, 44, 0, 1'b0, 1'b0);
    board[1] = 4'd0;
    applyStimulus("reprog no knight", 40, 44, -4, 1'b1, 1'b1);

    // Abort mid-scan: outputs must clear at once, and the table returns to defaults.
    loadStart();
    @(negedge clk); driveCtl(1'b1, 1'b0, 3'd0, 4'd0);
    @(negedge clk); driveCtl(1'b0, 1'b0, 3'd0, 4'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy",    int'(bus1.busy),      0);
    checkOutput("abort rd_en",   int'(bus1.rd_en),     0);
    checkOutput("abort rd_addr", int'(bus1.rd_addr),   0);
    checkOutput("abort score",   int'(bus1.score),     0);
    checkOutput("abort black",   int'(bus1.black_mat), 0);
    checkOutput("abort score L8", int'(bus8.score),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("after abort", 40, 40, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
    $finish;
  end
endmodule
